// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared word size and responder state encoding
// for the LEGv8 data-memory responder and its storage array.
package dmem_responder_pkg;

  localparam int WORDSIZE = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORDSIZE storage, async clear (rst low),
// async read at idx, sync write of wdata at idx when we.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       idx,
  input  logic [WORDSIZE-1:0] wdata,
  output logic [WORDSIZE-1:0] rdata
);

  logic [WORDSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with LATENCY
// wait states. Ports: req_* in (valid/ready), rsp_* out (valid/ready),
// busy = request in flight. rst is asynchronous, active low.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORDSIZE-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t         state, state_nx;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic [WORDSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [WORDSIZE-1:0] rdata_q;
  logic                err_q;

  logic [AW-1:0]       idx;
  logic                addr_err;
  logic                we;
  logic [WORDSIZE-1:0] arr_rdata;

  // Any bit above the index field is out of range; no aliasing.
  assign idx      = addr_q[AW+2:3];
  assign addr_err = (|addr_q[2:0]) |
                    (|addr_q[WORDSIZE-1:AW+3]);
  assign we       = (state == S_ACCESS) & write_q & ~addr_err;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .idx  (idx),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx = (LATENCY == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_nx = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
      end
      if (state == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Stores and rejected requests return zero data.
      if (state == S_ACCESS) begin
        rdata_q <= (addr_err | write_q) ? '0 : arr_rdata;
        err_q   <= addr_err;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder,
// plus a LATENCY=0 instance for timing and spacing checks.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_write = 1'b0;
  logic [63:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [63:0] b_rsp_rdata;
  logic        b_rsp_err;
  logic        b_busy;

  exp_t        q[$];
  logic [63:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode = 0;
  logic        prev_v = 1'b0;
  logic [63:0] held_d = '0;
  logic        held_e = 1'b0;
  exp_t        e_mon;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: drives rsp_ready, checks latency, stability, data.
  always @(negedge clk) begin
    if (!rst) begin
      prev_v    = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      case (mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
      if (rsp_valid) begin
        chk("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        if (!prev_v) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp want none");
          end else begin
            chk("rsp_latency", 64'(cyc),
                64'(q[0].acc + LAT + 1));
          end
        end else begin
          chk("hold_rdata", rsp_rdata, held_d);
          chk("hold_err", {63'd0, rsp_err}, {63'd0, held_e});
        end
        held_d = rsp_rdata;
        held_e = rsp_err;
        if (rsp_ready && q.size() != 0) begin
          e_mon = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e_mon.rdata);
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e_mon.err});
        end
      end
      prev_v = rsp_valid && !rsp_ready;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic issue(logic w, logic [63:0] a, logic [63:0] d);
    int   n;
    int   idx;
    logic er;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready want ready");
      req_valid = 1'b0;
      return;
    end
    er      = (a[2:0] != 3'd0) || (a >= 64'(DEPTH) * 64'd8);
    e.acc   = cyc + 1;
    e.err   = er;
    e.rdata = '0;
    if (!er) begin
      idx = int'(a >> 3);
      if (w) mem_m[idx] = d;
      else   e.rdata = mem_m[idx];
    end
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               q.size());
    end
  endtask

  task automatic hold_test();
    int n;
    mode = 1;
    issue(1'b0, 64'h10, '0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wait_valid", {63'd0, rsp_valid}, 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
    end
    #1 mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("req_ready_after_rsp", {63'd0, req_ready}, 64'd1);
    chk("busy_after_rsp", {63'd0, busy}, 64'd0);
    mode = 0;
  endtask

  task automatic reset_test();
    mode = 2;
    issue(1'b1, 64'h20, 64'h5555_AAAA_1234_5678);
    chk("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    q.delete();
    clear_model();
    #1;
    chk("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_rdata", rsp_rdata, 64'd0);
    chk("rst_mid_err", {63'd0, rsp_err}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    issue(1'b0, 64'h20, '0);
    issue(1'b0, 64'h10, '0);
    drain();
    mode = 0;
  endtask

  task automatic random_test();
    int          sel;
    logic [63:0] a;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      a   = 64'($urandom_range(0, 7)) * 64'd8;
      if ($urandom_range(0, 1) == 1) a = a + 64'd1984;
      case (sel)
        6: a = a + 64'($urandom_range(1, 7));
        7: a = 64'(DEPTH + $urandom_range(0, 7)) * 64'd8;
        8: a = 64'd1 << $urandom_range(11, 63);
        9: a = 64'h7F8;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), a,
            {$urandom, $urandom});
    end
    drain();
  endtask

  task automatic lat0_test();
    int nacc;
    int last_acc;
    nacc = 0;
    last_acc = -100;
    b_rsp_ready = 1'b1;
    b_req_addr  = 64'h8;
    b_req_wdata = 64'h1234;
    b_req_write = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b_req_write = (nacc == 0);
      if (b_rsp_valid) begin
        chk("lat0_latency", 64'(cyc), 64'(last_acc + 1));
        chk("lat0_rdata", b_rsp_rdata,
            (nacc == 1) ? 64'd0 : 64'h1234);
        chk("lat0_err", {63'd0, b_rsp_err}, 64'd0);
      end
      if (b_req_ready) begin
        if (last_acc >= 0) begin
          chk("lat0_spacing", 64'(cyc + 1 - last_acc), 64'd3);
        end
        last_acc = cyc + 1;
        nacc++;
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    chk("lat0_accepts_ge4", 64'(nacc >= 4), 64'd1);
  endtask

  initial begin
    clear_model();
    #1;
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", {63'd0, rsp_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    issue(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001);
    issue(1'b0, 64'h10, '0);
    issue(1'b0, 64'h0C, '0);
    issue(1'b0, 64'h08, '0);
    issue(1'b1, 64'h7F8, 64'hA5A5_0000_FFFF_0F0F);
    issue(1'b0, 64'h7F8, '0);
    issue(1'b1, 64'h800, 64'h1111_2222_3333_4444);
    issue(1'b0, 64'h800, '0);
    issue(1'b0, 64'h0, '0);
    drain();

    hold_test();
    drain();
    reset_test();
    random_test();
    lat0_test();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
